// File: rtl/ddsm_pkg.sv
// Shared definitions for the MASH mean decoder.
// Holds the default widths, the largest usable window exponent and the FSM
// state encoding used by the decoder top.
package ddsm_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned FracWDef = 24;
  localparam int unsigned AccWDef  = 32;

  // Largest window exponent; larger requests are clamped to this.
  localparam int unsigned K_MAX = 24;

  // The sample counter must be able to hold 2^K_MAX.
  localparam int unsigned CntW = K_MAX + 1;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StAcc,
    StDone
  } ddsm_state_e;

  function automatic logic [4:0] clamp_k(input logic [4:0] k);
    return (k > 5'(K_MAX)) ? 5'(K_MAX) : k;
  endfunction

endpackage

// File: rtl/ddsm_win_acc.sv
// Window accumulator for the MASH mean decoder.
// Sums the accepted samples, counts them against a 2^K window and flags the
// sample that completes the window. A carry out of the accumulator sets a
// sticky overflow flag.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clr_i     clear sum, count and overflow (measurement start)
//   add_i     accumulate sample_i this cycle
//   sample_i  sample to add (zero-extended)
//   k_i       window exponent, already clamped
//   sum_o     current accumulator value
//   last_o    add_i is accepting the final sample of the window
//   ovf_o     sticky accumulator carry-out
module ddsm_win_acc
  import ddsm_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ACC_W  = AccWDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [4:0]        k_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              last_o,
  output logic              ovf_o
);

  localparam int unsigned SumW = ACC_W + 1;

  logic [ACC_W-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q;
  logic [SumW-1:0]  sum_ext;

  // One extra bit catches the carry out of the accumulator.
  assign sum_ext = {1'b0, sum_q} + SumW'(sample_i);
  assign last_o  = add_i && ((cnt_q + CntW'(1)) == (CntW'(1) << k_i));
  assign sum_o   = sum_q;
  assign ovf_o   = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (add_i) begin
      sum_q <= sum_ext[ACC_W-1:0];
      cnt_q <= cnt_q + CntW'(1);
      if (sum_ext[ACC_W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddsm_mean_decoder.sv
// Receive-side mean decoder for the MASH divider-control stream.
// After discarding a programmable number of valid samples it averages 2^K
// valid samples and publishes the integer and left-aligned fractional ratio.
// Optional macro DDSM_DEC_SPAN_EN adds o_min/o_max: the spread of the
// accumulated samples, latched with the results.
// ACC_W must be at least DATA_W+FRAC_W.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start a measurement (honoured in IDLE or DONE)
//   i_win_log2          window exponent K, clamped to K_MAX
//   i_settle            valid samples to discard first
//   i_valid, i_mash_out sample stream
//   o_busy              settling or accumulating
//   o_done              one-cycle pulse when results update
//   o_int, o_frac       recovered ratio int.frac (held until next o_done)
//   o_ovf               sticky accumulator overflow, cleared on start
module ddsm_mean_decoder
  import ddsm_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned FRAC_W = FracWDef,
  parameter int unsigned ACC_W  = AccWDef
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [4:0]        i_win_log2,
  input  logic [7:0]        i_settle,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_mash_out,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_int,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_ovf
`ifdef DDSM_DEC_SPAN_EN
  ,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max
`endif
);

  ddsm_state_e state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [7:0]  settle_q, settle_d;
  logic        clr;
  logic        add;
  logic        acc_last;
  logic [ACC_W-1:0] acc_sum;

  logic [DATA_W-1:0] int_q, int_next;
  logic [FRAC_W-1:0] frac_q, frac_next, frac_low;
  logic [ACC_W-1:0]  low_mask;
  logic              done_q;

  assign add = (state_q == StAcc) && i_valid;

  ddsm_win_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_win_acc (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .clr_i    (clr),
    .add_i    (add),
    .sample_i (i_mash_out),
    .k_i      (k_q),
    .sum_o    (acc_sum),
    .last_o   (acc_last),
    .ovf_o    (o_ovf)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      settle_q <= settle_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    settle_d = settle_q;
    clr      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          k_d      = clamp_k(i_win_log2);
          settle_d = i_settle;
          clr      = 1'b1;
          state_d  = (i_settle != 8'd0) ? StSettle : StAcc;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        if (i_valid) begin
          settle_d = settle_q - 8'd1;
          // The S-th valid sample is still discarded.
          if (settle_q == 8'd1) begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (acc_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy flag and result alignment of the final sum
  always_comb begin
    o_busy    = (state_q == StSettle) || (state_q == StAcc);
    int_next  = DATA_W'(acc_sum >> k_q);
    low_mask  = (ACC_W'(1) << k_q) - ACC_W'(1);
    frac_low  = FRAC_W'(acc_sum & low_mask);
    // Left-align the K fractional bits; K=0 leaves frac_low at zero.
    frac_next = frac_low << (FRAC_W - 32'(k_q));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q <= 1'b0;
      int_q  <= '0;
      frac_q <= '0;
    end else begin
      done_q <= (state_q == StDone);
      if (state_q == StDone) begin
        int_q  <= int_next;
        frac_q <= frac_next;
      end
    end
  end

  assign o_done = done_q;
  assign o_int  = int_q;
  assign o_frac = frac_q;

`ifdef DDSM_DEC_SPAN_EN
  logic [DATA_W-1:0] run_min_q, run_max_q, min_q, max_q;
  logic              first_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_min_q <= '0;
      run_max_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
      first_q   <= 1'b1;
    end else begin
      if (clr) begin
        first_q <= 1'b1;
      end else if (add) begin
        first_q <= 1'b0;
        if (first_q || (i_mash_out < run_min_q)) run_min_q <= i_mash_out;
        if (first_q || (i_mash_out > run_max_q)) run_max_q <= i_mash_out;
      end
      if (state_q == StDone) begin
        min_q <= run_min_q;
        max_q <= run_max_q;
      end
    end
  end

  assign o_min = min_q;
  assign o_max = max_q;
`endif

endmodule
